snn_spike_decoder: RTL and testbench



---
 rtl/snn_pkg.sv | 19 +
 rtl/snn_sat_counter.sv | 28 ++
 rtl/snn_spike_decoder.sv | 113 +++++++++++
 tb/tb_snn_spike_decoder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network datapath blocks.
package snn_pkg;

    // Default output-layer width, shared with the network top.
    localparam int DEF_NUM_OUT = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ARGMAX,
        HOLD
    } dec_state_t;

    // Largest value an unsigned field of the given width can hold.
    function automatic int unsigned sat_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/snn_sat_counter.sv
// Saturating up-counter: synchronous clear, increments on inc, sticks at its maximum.
module snn_sat_counter
    import snn_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    // Count register: clear wins over increment, increment stops at CNT_MAX.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/snn_spike_decoder.sv
// Rate decoder: counts spikes per output neuron over a window, then scans
// for the most active neuron and offers the result through valid/ready.
module snn_spike_decoder
    import snn_pkg::*;
#(
    parameter  int NUM_OUT = DEF_NUM_OUT,
    parameter  int CNT_W   = 8,
    parameter  int WIN_W   = 10,
    localparam int IDX_W   = $clog2(NUM_OUT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIN_W-1:0]   win_len,
    input  logic [NUM_OUT-1:0] out_spk,
    output logic               busy,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [IDX_W-1:0]   class_idx,
    output logic [CNT_W-1:0]   class_cnt,
    output logic               no_spike
);

    dec_state_t       state;
    dec_state_t       state_nxt;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] win_cnt;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] best_idx;
    logic [CNT_W-1:0] best_cnt;
    logic [CNT_W-1:0] cnt [NUM_OUT];

    logic start_acc;
    logic accum_last;
    logic scan_last;
    logic take;

    assign start_acc  = (state == IDLE) && start;
    assign accum_last = (win_cnt == win_len_q - WIN_W'(1));
    assign scan_last  = (scan_idx == IDX_W'(NUM_OUT - 1));
    // Strictly greater keeps the earliest index on ties.
    assign take       = (cnt[scan_idx] > best_cnt);

    genvar i;
    generate
        for (i = 0; i < NUM_OUT; i++) begin : g_cnt
            snn_sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .clr   (start_acc),
                .inc   ((state == ACCUM) && out_spk[i]),
                .cnt   (cnt[i])
            );
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default first means every path assigns state_nxt, so no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start)        state_nxt = (win_len == '0) ? ARGMAX : ACCUM;
            ACCUM:   if (accum_last)   state_nxt = ARGMAX;
            ARGMAX:  if (scan_last)    state_nxt = HOLD;
            HOLD:    if (result_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Window counter, argmax scan pointer and running best candidate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_len_q <= '0;
            win_cnt   <= '0;
            scan_idx  <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
        end else if (start_acc) begin
            win_len_q <= win_len;
            win_cnt   <= '0;
            scan_idx  <= '0;
            best_idx  <= '0;
            best_cnt  <= '0;
        end else if (state == ACCUM) begin
            win_cnt <= win_cnt + WIN_W'(1);
        end else if (state == ARGMAX) begin
            scan_idx <= scan_idx + IDX_W'(1);
            if (take) begin
                best_idx <= scan_idx;
                best_cnt <= cnt[scan_idx];
            end
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == HOLD);
    assign class_idx    = best_idx;
    assign class_cnt    = best_cnt;
    // Qualified by HOLD so the flag reads 0 out of reset and between results.
    assign no_spike     = (state == HOLD) && (best_cnt == '0);

endmodule

// File: tb/tb_snn_spike_decoder.sv
// Directed bench for snn_spike_decoder with hand-computed expected results.
module tb_snn_spike_decoder;

    localparam int NUM_OUT = 8;
    localparam int CNT_W   = 8;
    localparam int WIN_W   = 10;
    localparam int IDX_W   = 3;
    localparam int MAX_WAIT = 2000;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [WIN_W-1:0]   win_len;
    logic [NUM_OUT-1:0] out_spk;
    logic               busy;
    logic               result_valid;
    logic               result_ready;
    logic [IDX_W-1:0]   class_idx;
    logic [CNT_W-1:0]   class_cnt;
    logic               no_spike;

    int n_vec = 0;
    int n_err = 0;

    snn_spike_decoder #(
        .NUM_OUT (NUM_OUT),
        .CNT_W   (CNT_W),
        .WIN_W   (WIN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .win_len      (win_len),
        .out_spk      (out_spk),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .class_idx    (class_idx),
        .class_cnt    (class_cnt),
        .no_spike     (no_spike)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge: one new cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_valid"}, 32'(result_valid), 0);
        check({tag, "_idx"},   32'(class_idx), 0);
        check({tag, "_cnt"},   32'(class_cnt), 0);
        check({tag, "_nospk"}, 32'(no_spike), 0);
    endtask

    // Called positioned in cycle T with the DUT idle; returns in cycle H+1.
    task automatic run_window(input string tag, input int win, input logic [NUM_OUT-1:0] spk,
                              input int exp_idx, input int exp_cnt, input int exp_ns);
        int k;
        start        = 1'b1;
        win_len      = WIN_W'(win);
        out_spk      = spk;
        result_ready = 1'b1;
        k = 0;
        do begin
            step();
            k++;
            start = 1'b0;
            if (k == 1) check({tag, "_busy_T1"}, 32'(busy), 1);
        end while (!result_valid && k < MAX_WAIT);
        check({tag, "_latency"}, k, win + NUM_OUT + 1);
        check({tag, "_idx"}, 32'(class_idx), exp_idx);
        check({tag, "_cnt"}, 32'(class_cnt), exp_cnt);
        check({tag, "_nospk"}, 32'(no_spike), exp_ns);
        step();
        check({tag, "_valid_H1"}, 32'(result_valid), 0);
        check({tag, "_busy_H1"}, 32'(busy), 0);
    endtask

    initial begin
        int k;
        int bad;

        reset        = 1'b0;
        start        = 1'b0;
        win_len      = '0;
        out_spk      = '0;
        result_ready = 1'b0;
        step();
        step();
        check_outputs_zero("reset");
        reset = 1'b1;
        step();

        // Back-to-back windows, each next start issued in cycle H+1.
        run_window("one_hot",  10,  8'h04, 2, 10,  0);
        run_window("tie",      4,   8'h22, 1, 4,   0);
        run_window("saturate", 300, 8'h80, 7, 255, 0);
        run_window("win_zero", 0,   8'hff, 0, 0,   1);
        run_window("silent",   6,   8'h00, 0, 0,   1);

        // Backpressure: result held while ready is low, starts ignored.
        start        = 1'b1;
        win_len      = WIN_W'(3);
        out_spk      = 8'h08;
        result_ready = 1'b0;
        k = 0;
        do begin
            step();
            k++;
            start = 1'b0;
        end while (!result_valid && k < MAX_WAIT);
        check("bp_latency", k, 3 + NUM_OUT + 1);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            start   = (c == 2);
            win_len = WIN_W'(7);
            out_spk = 8'hff;
            if (!result_valid || class_idx !== 3'd3 || class_cnt !== 8'd3 || no_spike !== 1'b0)
                bad++;
            step();
        end
        check("bp_stable_cycles_bad", bad, 0);
        check("bp_still_valid", 32'(result_valid), 1);
        // Handshake cycle; start here must also be ignored.
        start        = 1'b1;
        result_ready = 1'b1;
        step();
        start = 1'b0;
        check("bp_valid_H1", 32'(result_valid), 0);
        check("bp_busy_H1", 32'(busy), 0);
        run_window("after_bp", 2, 8'h10, 4, 2, 0);

        // Reset in cycle T+3 of a 10-step window aborts it.
        start   = 1'b1;
        win_len = WIN_W'(10);
        out_spk = 8'hff;
        for (int c = 0; c < 3; c++) begin
            step();
            start = 1'b0;
        end
        check("abort_busy_before", 32'(busy), 1);
        reset = 1'b0;
        #1;
        check_outputs_zero("abort");
        step();
        step();
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (result_valid || busy) bad++;
        end
        check("abort_no_partial", bad, 0);
        run_window("fresh", 5, 8'h01, 0, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
